json_cmd_serializer: RTL and testbench
======================================

# json_cmd_serializer

Parametrised successor to the fixed-string command translator. Accepts a drive command (type digit plus signed left/right wheel speeds in hundredths) over a valid/ready handshake and formats it numerically into an ASCII JSON frame, e.g. {"T":1,"L":-0.50,"R":0.50}. It streams the frame byte-by-byte into the UART transmitter under a byte-level valid/ready handshake. An optional idle watchdog sends a stop frame automatically when commands stop arriving.

## Interface
Parameters:
- SPEED_W, 8: signed speed width, two's complement, units of 0.01.
- APPEND_NL, 1: 1 appends '\n' (0x0A) after '}'.
- TIMEOUT_CYCLES, 0: idle cycles before an automatic stop frame; 0 disables the watchdog.

Ports:
- Single clock domain; reset is synchronous, active-high.
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_type  in  4  T field, decimal 0..9.
- cmd_left  in  SPEED_W  left speed, signed hundredths.
- cmd_right  in  SPEED_W  right speed, signed hundredths.
- tx_data  out  8  ASCII byte to UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts the byte.
- busy  out  1  a frame is in flight.
- err  out  1  one-cycle pulse: the accepted command was invalid or clamped.
- timeout  out  1  one-cycle pulse: a watchdog stop frame was launched.

## Operation
- FSM states: IDLE and SEND.
- IDLE: cmd_ready=1. When cmd_valid is high, latch type, left and right, then go to SEND.
- SEND: cmd_ready=0. Emit frame bytes in order; the byte index advances only on tx_valid&&tx_ready. After the handshake of the last byte, return to IDLE.
- Frame layout: {"T":t,"L":sL.DD,"R":sR.DD} followed by optional '\n'.
  - t is a single ASCII digit.
  - s is '-' only when the value is negative; 0 prints as "0.00".
  - L is the integer digit: magnitude ≥100 → '1', else '0'.
  - The two fractional digits are (magnitude mod 100) split into tens and ones.
- Frame length:
  - Base 25 bytes.
  - +1 for each negative speed.
  - +1 if APPEND_NL.
  - Range 25..28.
- Speed saturation: speeds outside -100..100 are clamped to ±100 and err pulses.
- Invalid type: cmd_type > 9 transmits a stop frame (T 0, both speeds 0.00) and err pulses.
- err is evaluated at acceptance.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter clears on reset and on each accepted command or frame completion.
  - It counts only in IDLE.
  - When it reaches TIMEOUT_CYCLES with cmd_valid low, latch a stop frame, pulse timeout and enter SEND.
  - If cmd_valid is high on that same cycle, the command wins and the counter clears.
- Digit formatting uses subtract/compare only; no divider.

## Timing
- Reset values: cmd_ready=0 during rst, 1 the cycle after. All other outputs are 0: tx_data, tx_valid, busy, err, timeout. State returns to IDLE and the byte index to 0.
- Reset mid-frame aborts the frame immediately; the next frame restarts at '{'.
- Command acceptance at cycle N → tx_valid=1 with tx_data='{' at N+1. busy=1 from N+1 until the cycle after the last byte handshake.
- While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
- A back-to-back tx_ready stream gives one byte per cycle.
- After the last handshake at cycle M: tx_valid=0 and cmd_ready=1 at M+1. The earliest next command is accepted at M+1.
- err and timeout are high exactly one cycle: the cycle after acceptance/launch, aligned with the first tx_valid.

## Structure
- Package json_cmd_pkg holds:
  - the ASCII constants ('{', '}', '"', ':', ',', '.', '-', '0', 'T', 'L', 'R', '\n');
  - the state enum;
  - the frame-slot enum (OPEN, TKEY, TVAL, LKEY, LSIGN, LINT, DOT, LFRAC1, LFRAC2, …, CLOSE, NL);
  - MAX_FRAME_LEN=28.
- One sub-module, speed_fmt (combinational): signed SPEED_W in → neg flag, integer, tens and ones ASCII digits, sat flag. Instantiated twice.
- Frame sequencing walks slot enums and skips sign slots when the value is not negative.

## Test plan
- type=1, L=50, R=50, tx_ready always 1 → 26 bytes {"T":1,"L":0.50,"R":0.50}\n on consecutive cycles; cmd_ready=1 again the cycle after '\n'.
- type=2, L=-7, R=100 with tx_ready toggling every other cycle → {"T":2,"L":-0.07,"R":1.00}\n; tx_data is stable during every stall.
- type=12, L=30, R=30 → {"T":0,"L":0.00,"R":0.00}\n plus a single err pulse. Separately, L=127 → "1.00" with err.
- TIMEOUT_CYCLES=10, no commands after reset → stop frame starts after 10 idle cycles, timeout pulses once. With cmd_valid asserted on the expiry cycle, the command frame is sent instead and there is no timeout pulse.
- rst asserted after the 8th byte of a frame → all outputs 0, cmd_ready=1 next cycle; a new command restarts at '{'.

Source files
------------

// File: rtl/json_cmd_serializer_pkg.sv
// json_cmd_pkg: ASCII constants, FSM/slot enums and digit struct shared by the JSON command serializer
package json_cmd_pkg;
  localparam logic [7:0] A_LBRACE = 8'h7B;
  localparam logic [7:0] A_RBRACE = 8'h7D;
  localparam logic [7:0] A_QUOTE  = 8'h22;
  localparam logic [7:0] A_COLON  = 8'h3A;
  localparam logic [7:0] A_COMMA  = 8'h2C;
  localparam logic [7:0] A_DOT    = 8'h2E;
  localparam logic [7:0] A_MINUS  = 8'h2D;
  localparam logic [7:0] A_ZERO   = 8'h30;
  localparam logic [7:0] A_T      = 8'h54;
  localparam logic [7:0] A_L      = 8'h4C;
  localparam logic [7:0] A_R      = 8'h52;
  localparam logic [7:0] A_NL     = 8'h0A;
  localparam int MAX_FRAME_LEN = 28;
  typedef enum logic {ST_IDLE, ST_SEND} state_e;
  typedef enum logic [4:0] {
    S_OPEN, S_TQ0, S_TKEY, S_TQ1, S_TCOL, S_TVAL, S_TCOM,
    S_LQ0, S_LKEY, S_LQ1, S_LCOL, S_LSIGN, S_LINT, S_LDOT, S_LFRAC1, S_LFRAC2, S_LCOM,
    S_RQ0, S_RKEY, S_RQ1, S_RCOL, S_RSIGN, S_RINT, S_RDOT, S_RFRAC1, S_RFRAC2,
    S_CLOSE, S_NL
  } slot_e;
  typedef struct packed {
    logic       neg;
    logic [7:0] ip;
    logic [7:0] tens;
    logic [7:0] ones;
  } spd_t;
  localparam spd_t SPD_ZERO = '{neg: 1'b0, ip: A_ZERO, tens: A_ZERO, ones: A_ZERO};
endpackage

// File: rtl/json_cmd_serializer_speed_fmt.sv
// speed_fmt: signed hundredths speed -> clamped sign flag and three ASCII digits (no divider)
module speed_fmt
  import json_cmd_pkg::*;
#(
  parameter int SPEED_W = 8
) (
  input  logic signed [SPEED_W-1:0] val_i,
  output spd_t                      fmt_o,
  output logic                      sat_o
);
  logic signed [31:0] v;
  logic [6:0] mag, rem;
  logic [3:0] tens;
  always_comb begin
    v = 32'(val_i);
    sat_o = (v > 32'sd100) || (v < -32'sd100);
    mag = sat_o ? 7'd100 : 7'(v < 0 ? -v : v);
    rem = mag >= 7'd100 ? mag - 7'd100 : mag;
    tens = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (rem >= 7'd10) begin
        rem = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    fmt_o.neg = v < 0;
    fmt_o.ip = mag >= 7'd100 ? A_ZERO + 8'd1 : A_ZERO;
    fmt_o.tens = A_ZERO + {4'h0, tens};
    fmt_o.ones = A_ZERO + {1'b0, rem};
  end
endmodule

// File: rtl/json_cmd_serializer.sv
// json_cmd_serializer: drive command -> streamed ASCII JSON frame {"T":t,"L":x.xx,"R":x.xx} with idle stop watchdog
module json_cmd_serializer
  import json_cmd_pkg::*;
#(
  parameter int SPEED_W        = 8,
  parameter bit APPEND_NL      = 1'b1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_type,
  input  logic [SPEED_W-1:0] cmd_left,
  input  logic [SPEED_W-1:0] cmd_right,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               err,
  output logic               timeout
);
  localparam int WD_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  state_e state_q, state_d;
  slot_e slot_q, slot_d, nxt;
  spd_t l_q, l_d, r_q, r_d, l_fmt, r_fmt;
  logic [7:0] tval_q, tval_d, byte_c;
  logic [WD_W-1:0] wd_q, wd_d;
  logic err_q, err_d, tmo_q, tmo_d;
  logic l_sat, r_sat, bad_type, accept, wd_fire, hs, last;
  speed_fmt #(.SPEED_W(SPEED_W)) u_fmt_l (.val_i(cmd_left), .fmt_o(l_fmt), .sat_o(l_sat));
  speed_fmt #(.SPEED_W(SPEED_W)) u_fmt_r (.val_i(cmd_right), .fmt_o(r_fmt), .sat_o(r_sat));
  assign busy = state_q == ST_SEND;
  assign tx_valid = busy;
  assign cmd_ready = state_q == ST_IDLE && !rst;
  assign err = err_q;
  assign timeout = tmo_q;
  assign tx_data = busy ? byte_c : 8'h00;
  assign bad_type = cmd_type > 4'd9;
  assign accept = cmd_valid && cmd_ready;
  assign wd_fire = TIMEOUT_CYCLES != 0 && state_q == ST_IDLE && !cmd_valid && wd_q == WD_W'(TIMEOUT_CYCLES);
  assign hs = tx_valid && tx_ready;
  assign last = slot_q == S_NL || (slot_q == S_CLOSE && !APPEND_NL);
  // sign slots are only visited for negative speeds
  always_comb begin
    nxt = slot_e'(slot_q + 5'd1);
    if (nxt == S_LSIGN && !l_q.neg) nxt = S_LINT;
    if (nxt == S_RSIGN && !r_q.neg) nxt = S_RINT;
  end
  always_comb begin
    byte_c = 8'h00;
    case (slot_q)
      S_OPEN:                                    byte_c = A_LBRACE;
      S_TQ0, S_TQ1, S_LQ0, S_LQ1, S_RQ0, S_RQ1:  byte_c = A_QUOTE;
      S_TKEY:                                    byte_c = A_T;
      S_LKEY:                                    byte_c = A_L;
      S_RKEY:                                    byte_c = A_R;
      S_TCOL, S_LCOL, S_RCOL:                    byte_c = A_COLON;
      S_TCOM, S_LCOM:                            byte_c = A_COMMA;
      S_TVAL:                                    byte_c = tval_q;
      S_LSIGN, S_RSIGN:                          byte_c = A_MINUS;
      S_LDOT, S_RDOT:                            byte_c = A_DOT;
      S_LINT:                                    byte_c = l_q.ip;
      S_LFRAC1:                                  byte_c = l_q.tens;
      S_LFRAC2:                                  byte_c = l_q.ones;
      S_RINT:                                    byte_c = r_q.ip;
      S_RFRAC1:                                  byte_c = r_q.tens;
      S_RFRAC2:                                  byte_c = r_q.ones;
      S_CLOSE:                                   byte_c = A_RBRACE;
      S_NL:                                      byte_c = A_NL;
      default:                                   byte_c = 8'h00;
    endcase
  end
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    l_d = l_q;
    r_d = r_q;
    tval_d = tval_q;
    wd_d = wd_q;
    err_d = 1'b0;
    tmo_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        state_d = ST_SEND;
        slot_d = S_OPEN;
        tval_d = bad_type ? A_ZERO : A_ZERO + {4'h0, cmd_type};
        l_d = bad_type ? SPD_ZERO : l_fmt;
        r_d = bad_type ? SPD_ZERO : r_fmt;
        err_d = bad_type || l_sat || r_sat;
        wd_d = '0;
      end else if (wd_fire) begin
        state_d = ST_SEND;
        slot_d = S_OPEN;
        tval_d = A_ZERO;
        l_d = SPD_ZERO;
        r_d = SPD_ZERO;
        tmo_d = 1'b1;
        wd_d = '0;
      end else if (TIMEOUT_CYCLES != 0) begin
        wd_d = wd_q + 1'b1;
      end
    end else if (hs) begin
      slot_d = last ? S_OPEN : nxt;
      state_d = last ? ST_IDLE : ST_SEND;
      wd_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot_q <= S_OPEN;
      l_q <= SPD_ZERO;
      r_q <= SPD_ZERO;
      tval_q <= A_ZERO;
      wd_q <= '0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      l_q <= l_d;
      r_q <= r_d;
      tval_q <= tval_d;
      wd_q <= wd_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end
endmodule

// File: tb/tb_json_cmd_serializer.sv
// tb_json_cmd_serializer: scoreboard bench with a string-formatting reference model of the JSON frames
module tb_json_cmd_serializer;
  localparam int SW = 8;
  localparam int TMO = 10;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, tx_ready = 1'b1;
  logic [3:0] cmd_type = 4'd0;
  logic [SW-1:0] cmd_left = '0, cmd_right = '0;
  logic cmd_ready, tx_valid, busy, err, timeout;
  logic [7:0] tx_data;
  int tests = 0, fails = 0, rdy_mode = 0;
  logic [7:0] exp_q[$];
  logic [1:0] flg_q[$];
  logic pv = 1'b0, stall = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [1:0] f;
  always #5 clk = ~clk;
  json_cmd_serializer #(.SPEED_W(SW), .APPEND_NL(1'b1), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .err(err), .timeout(timeout)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic string fmt_speed(input int v);
    int m;
    string sg;
    m = v < 0 ? -v : v;
    sg = "";
    if (v < 0) sg = "-";
    return $sformatf("%s%0d.%0d%0d", sg, m / 100, (m % 100) / 10, m % 10);
  endfunction
  task automatic expect_frame(input int t, input int l, input int r, input bit tmo);
    int cl, cr;
    bit e;
    string s;
    cl = l > 100 ? 100 : (l < -100 ? -100 : l);
    cr = r > 100 ? 100 : (r < -100 ? -100 : r);
    e = !tmo && (t > 9 || cl != l || cr != r);
    if (tmo || t > 9) begin
      t = 0;
      cl = 0;
      cr = 0;
    end
    s = $sformatf("{\"T\":%0d,\"L\":%s,\"R\":%s}\n", t, fmt_speed(cl), fmt_speed(cr));
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    flg_q.push_back({e, tmo});
  endtask
  task automatic send_cmd(input int t, input int l, input int r);
    int n;
    n = 0;
    cmd_type = 4'(t);
    cmd_left = 8'(l);
    cmd_right = 8'(r);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    expect_frame(t, l, r, 1'b0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask
  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~tx_ready : ($urandom_range(0, 2) != 0);
  end
  always @(negedge clk) begin
    if (rst) begin
      pv <= 1'b0;
      stall <= 1'b0;
    end else begin
      if (tx_valid && !pv) begin
        if (flg_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL frame_start: unexpected frame, none expected");
        end else begin
          f = flg_q.pop_front();
          check("err_pulse", {31'd0, err}, {31'd0, f[1]});
          check("timeout_pulse", {31'd0, timeout}, {31'd0, f[0]});
        end
      end else if (err || timeout) begin
        tests++;
        fails++;
        $display("FAIL stray_pulse: err=%0b timeout=%0b expected 0", err, timeout);
      end
      if (stall) begin
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_data}, {24'd0, pd});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_byte: got %0h expected no byte", tx_data);
        end else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      stall <= tx_valid && !tx_ready;
      pd <= tx_data;
      pv <= tx_valid;
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, l, r;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rdy_mode = 0;
    send_cmd(1, 50, 50);
    check("t1_first_valid", {31'd0, tx_valid}, 32'd1);
    check("t1_first_byte", {24'd0, tx_data}, 32'h7B);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    repeat (25) @(posedge clk);
    #1;
    check("t1_last_byte", {24'd0, tx_data}, 32'h0A);
    @(posedge clk);
    #1;
    check("t1_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("t1_valid_after", {31'd0, tx_valid}, 32'd0);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    rdy_mode = 1;
    send_cmd(2, -7, 100);
    wait_drain();
    rdy_mode = 0;
    send_cmd(12, 30, 30);
    send_cmd(3, 127, -20);
    wait_drain();
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      t = int'($urandom_range(0, 11));
      l = $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 200)) - 100 : int'($urandom_range(0, 255)) - 128;
      r = $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 200)) - 100 : int'($urandom_range(0, 255)) - 128;
      send_cmd(t, l, r);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain();
    rdy_mode = 0;
    send_cmd(4, -100, -55);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("ar_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("ar_tx_data", {24'd0, tx_data}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_err", {31'd0, err}, 32'd0);
    check("ar_timeout", {31'd0, timeout}, 32'd0);
    check("ar_cmd_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("ar_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    send_cmd(5, 99, -1);
    check("ar_restart_byte", {24'd0, tx_data}, 32'h7B);
    wait_drain();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_frame(0, 0, 0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("wd_quiet", {31'd0, tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("wd_launch_valid", {31'd0, tx_valid}, 32'd1);
    check("wd_launch_byte", {24'd0, tx_data}, 32'h7B);
    check("wd_launch_pulse", {31'd0, timeout}, 32'd1);
    wait_drain();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send_cmd(7, -45, 88);
    check("wd_race_valid", {31'd0, tx_valid}, 32'd1);
    check("wd_race_no_timeout", {31'd0, timeout}, 32'd0);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("final_flags_empty", flg_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
